// File: rtl/d_mem_pkg.sv
// d_mem_pkg: shared state type, default sizes and byte-lane helper for the data memory
package d_mem_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int DSIZE_DEF = 16;
  localparam int MEM_SPACE_DEF = 8;
  function automatic int lanes(input int dsize);
    return dsize / 8;
  endfunction
endpackage

// File: rtl/d_mem_array.sv
// d_mem_array: word storage with one synchronous lane-masked write port and a registered read port
// Ports: clk, rst (clears rdata only), we/wmask/waddr/wdata write port, re/raddr read port, rdata registered read data
module d_mem_array #(
  parameter int DSIZE = 16,
  parameter int AW = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [LANES-1:0] wmask,
  input  logic [AW-1:0]    waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [DSIZE-1:0] rdata
);
  localparam int LW = DSIZE / LANES;
  logic [DSIZE-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < LANES; i++)
        if (wmask[i]) mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: data memory controller with valid/ready requests, 1-cycle registered reads and a zero-fill clear sequencer
// Ports: clk, rst (sync active-high), clear_req, req_valid/req_ready, address, data_in, write_en (active-low write),
//        byte_en (only with D_MEM_BYTE_WE_EN), data_out, rsp_valid, busy
// Option: define D_MEM_BYTE_WE_EN to add per-byte write enables (DSIZE must be a multiple of 8)
module d_mem_ctrl import d_mem_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int MEM_SPACE = MEM_SPACE_DEF,
  parameter logic [DSIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MEM_SPACE-1:0] address,
  input  logic [DSIZE-1:0]     data_in,
  input  logic                 write_en,
`ifdef D_MEM_BYTE_WE_EN
  input  logic [lanes(DSIZE)-1:0] byte_en,
`endif
  output logic [DSIZE-1:0]     data_out,
  output logic                 rsp_valid,
  output logic                 busy
);
`ifdef D_MEM_BYTE_WE_EN
  localparam int LANES = lanes(DSIZE);
  if (DSIZE % 8 != 0) begin : g_dsize_chk
    $error("d_mem_ctrl: DSIZE must be a multiple of 8 with byte write enables");
  end
`else
  localparam int LANES = 1;
`endif
  localparam int DEPTH = 2**MEM_SPACE;
  state_t                 state;
  logic [MEM_SPACE:0]     clr_cnt;
  logic                   accept, clearing, we, re;
  logic [MEM_SPACE-1:0]   waddr;
  logic [DSIZE-1:0]       wdata;
  logic [LANES-1:0]       wmask, req_mask;
`ifdef D_MEM_BYTE_WE_EN
  assign req_mask = byte_en;
`else
  assign req_mask = '1;
`endif
  assign req_ready = (state == READY) && !clear_req;
  assign busy      = (state == CLEAR);
  assign accept    = req_ready && req_valid;
  // rst suppresses every write so an aborted clear leaves no partial side effects this edge
  assign clearing  = busy && !rst;
  assign we        = clearing || (!rst && accept && !write_en);
  assign re        = !rst && accept && write_en;
  assign waddr     = clearing ? clr_cnt[MEM_SPACE-1:0] : address;
  assign wdata     = clearing ? INIT_VALUE : data_in;
  assign wmask     = clearing ? '1 : req_mask;
  d_mem_array #(.DSIZE(DSIZE), .AW(MEM_SPACE), .LANES(LANES)) u_array (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(address), .rdata(data_out)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= accept && write_en;
      if (clear_req) begin
        state   <= CLEAR;
        clr_cnt <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == (MEM_SPACE+1)'(DEPTH-1)) state <= READY;
      end
    end
endmodule

// File: tb/tb_d_mem_ctrl.sv
// tb_d_mem_ctrl: directed self-checking bench for d_mem_ctrl
module tb_d_mem_ctrl;
  logic        clk = 0, rst = 1, clear_req = 0, req_valid = 0, write_en = 1;
  logic [7:0]  address = '0;
  logic [15:0] data_in = '0, data_out;
  logic        req_ready, rsp_valid, busy;
  logic [1:0]  byte_en = 2'b11;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  d_mem_ctrl dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .data_in(data_in), .write_en(write_en),
`ifdef D_MEM_BYTE_WE_EN
    .byte_en(byte_en),
`endif
    .data_out(data_out), .rsp_valid(rsp_valid), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      n++;
      step();
    end
    check(tag, n, 256);
    check({tag, "_ready"}, req_ready, 1);
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    req_valid = 1; write_en = 0; address = a; data_in = d; byte_en = be;
    step();
    req_valid = 0; write_en = 1; byte_en = 2'b11;
  endtask
  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    req_valid = 1; write_en = 1; address = a;
    step();
    req_valid = 0;
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, data_out, exp);
  endtask
  initial begin
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_dout", data_out, 0);
    rst = 0;
    count_busy("init_busy");
    rd("rd_ff", 8'hFF, 16'h0000);
    wr(8'h10, 16'hBEEF, 2'b11);
    check("wr_no_rsp", rsp_valid, 0);
    rd("rd_10", 8'h10, 16'hBEEF);
    step();
    check("rd_10_once", rsp_valid, 0);
    wr(8'h00, 16'h1111, 2'b11);
    wr(8'h01, 16'h2222, 2'b11);
    wr(8'h02, 16'h3333, 2'b11);
    wr(8'h03, 16'h4444, 2'b11);
    req_valid = 1; write_en = 1;
    for (int i = 0; i < 4; i++) begin
      address = 8'(i);
      step();
      check($sformatf("b2b%0d_valid", i), rsp_valid, 1);
      check($sformatf("b2b%0d_data", i), data_out, 32'h1111 * (i + 1));
    end
    req_valid = 0;
    step();
    check("b2b_end", rsp_valid, 0);
    req_valid = 1; write_en = 0; address = 8'h05; data_in = 16'hAAAA; clear_req = 1;
    #1;
    check("clr_prio_ready", req_ready, 0);
    step();
    clear_req = 0; req_valid = 0; write_en = 1;
    check("clr_no_rsp", rsp_valid, 0);
    count_busy("clr_busy");
    rd("rd_05", 8'h05, 16'h0000);
    rd("rd_10_cleared", 8'h10, 16'h0000);
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 0; i < 128; i++) step();
    check("mid_clear_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    count_busy("rst_mid_clear");
    wr(8'h07, 16'h5A5A, 2'b11);
    rd("rd_07", 8'h07, 16'h5A5A);
    req_valid = 1; address = 8'h07;
    step();
    req_valid = 0;
    check("pre_rst_valid", rsp_valid, 1);
    rst = 1;
    step();
    check("rst_drop_valid", rsp_valid, 0);
    check("rst_drop_dout", data_out, 0);
    rst = 0;
    count_busy("rst_rd_busy");
`ifdef D_MEM_BYTE_WE_EN
    wr(8'h20, 16'h1234, 2'b11);
    wr(8'h20, 16'hABCD, 2'b10);
    rd("byte_hi", 8'h20, 16'hAB34);
    wr(8'h20, 16'h00EF, 2'b01);
    rd("byte_lo", 8'h20, 16'hABEF);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/d_mem_ctrl.md
# d_mem_ctrl

Parametrised data memory for the CE3001 datapath and the next generation of the fixed 16-bit data store. It keeps the active-low write-enable convention and adds a valid/ready request handshake, a registered read response with a valid strobe, and a hardware clear sequencer. The clear sequencer replaces file-based initialisation with a cycle-counted zero-fill that can also be re-run at runtime. It sits between the MEM pipeline stage and on-chip RAM.

## Interface
- `DSIZE`, 16, data word width in bits.
- `MEM_SPACE`, 8, address width; depth = 2**MEM_SPACE words.
- `INIT_VALUE`, 0, word written to every location by the clear sequencer.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `clear_req` in 1: single-cycle pulse requesting a full re-clear.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted at this edge if `req_valid` is also high.
- `address` in MEM_SPACE: word address.
- `data_in` in DSIZE: write data.
- `write_en` in 1: active-low; 0 = write, 1 = read.
- `data_out` out DSIZE: registered read data.
- `rsp_valid` out 1: `data_out` holds a new read result this cycle.
- `busy` out 1: clear sequence in progress.

## Operation
- FSM states:
  - CLEAR: walks `clr_cnt` 0 to DEPTH-1, writing INIT_VALUE to one location per cycle.
  - READY: serves requests.
- Transitions:
  - `rst` forces CLEAR with `clr_cnt`=0.
  - CLEAR goes to READY at the edge that writes DEPTH-1.
  - READY goes to CLEAR, with `clr_cnt`=0, on `clear_req`.
- `req_ready` = (state==READY) && !`clear_req`.
- `busy` = (state==CLEAR).
- Accepted write (`write_en`=0): mem[`address`] <= `data_in`. `rsp_valid` is 0 next cycle and `data_out` is unchanged.
- Accepted read (`write_en`=1): `data_out` <= mem[`address`] and `rsp_valid` <= 1 for exactly one cycle.
- Requests with `req_ready`=0 are ignored and have no side effects. The requester holds `req_valid` and its fields until accepted.
- `clear_req` during CLEAR restarts `clr_cnt` at 0.
- `clear_req` takes priority over a simultaneous request in READY; that request is not accepted.
- Address arithmetic is MEM_SPACE bits wide. `clr_cnt` is MEM_SPACE+1 bits and never wraps into a second pass.
- Reset values:
  - state=CLEAR, `clr_cnt`=0.
  - `data_out`=0, `rsp_valid`=0.
  - `busy`=1, `req_ready`=0.
- Memory contents are undefined until the first clear completes.

## Timing
- Read latency is 1 cycle. A read accepted at edge N gives `rsp_valid`=1 and valid `data_out` in the cycle after edge N.
- Throughput is one request per cycle; back-to-back reads produce back-to-back `rsp_valid`.
- A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Clear duration: the cycle after reset deasserts, `busy`=1 for exactly 2**MEM_SPACE cycles, then `req_ready` rises.
- Reset mid-operation: the next edge with `rst`=1 drops `rsp_valid` and aborts any clear. The clear restarts from address 0 once `rst` falls.

## Configuration
- Macro `D_MEM_BYTE_WE_EN`.
  - Defined: adds input `byte_en` [DSIZE/8-1:0]. On an accepted write, only the bytes whose `byte_en` bit is 1 are updated. DSIZE must be a multiple of 8; elaboration fails otherwise. The clear sequencer always writes all bytes.
  - Undefined: no `byte_en` port; every write updates the whole word.

## Structure
- Package `d_mem_pkg`:
  - state enum (CLEAR, READY);
  - default DSIZE/MEM_SPACE constants;
  - byte-lane count helper.
- Sub-module `d_mem_array`: storage only, with one synchronous write port (optional byte mask) and a registered read port.
- `d_mem_ctrl` holds the FSM, clear counter, handshake and write-port muxing between the sequencer and requests.

## Test plan
- Reset, then count cycles. Required: `busy`=1 for 256 cycles (MEM_SPACE=8), then `req_ready`=1. A read of 0xFF returns INIT_VALUE with `rsp_valid` one cycle after acceptance.
- Write 0xBEEF to 0x10, next cycle read 0x10. Required: `data_out`=0xBEEF and `rsp_valid`=1 exactly one cycle later. The write cycle produces no `rsp_valid`.
- Four back-to-back reads of 0x00–0x03 after writing 0x1111–0x4444. Required: four consecutive `rsp_valid` cycles returning 0x1111, 0x2222, 0x3333, 0x4444 in order.
- Pulse `clear_req` in the same cycle as a write of 0xAAAA to 0x05. Required: write not accepted, `busy` high for 256 cycles, and address 0x05 reads INIT_VALUE afterwards.
- Assert `rst` halfway through a clear and during an outstanding read. Required: `rsp_valid`=0 next cycle, and the clear restarts with a full 256 busy cycles.
- With `D_MEM_BYTE_WE_EN`: store 0x1234 at 0x20, write 0xABCD with `byte_en`=2'b10. Required: a read returns 0xAB34.
